// File: rtl/usbfs_pkg.sv
// Shared types for the USB FS OUT-packet scheduler: FSM states, handshake
// decisions and the fixed endpoint-number width.
package usbfs_pkg;

   localparam int ENDP_W = 4;

   typedef enum logic [1:0] {IDLE, RESP, DRAIN, TAIL} state_e;

   typedef enum logic [1:0] {HS_ACK, HS_NAK, HS_STALL} hs_e;

endpackage

// File: rtl/usbfs_rd_mux.sv
// N_ENDP:1 read-port select. Forwards the selected endpoint's read strobe
// and index to the shared buffer only while the grant input is high; all
// other endpoints' strobes are dropped.
module usbfs_rd_mux
   import usbfs_pkg::*;
#(
   parameter int N_ENDP = 4,
   parameter int IDX_W  = 3
) (
   input  logic [ENDP_W-1:0]       i_sel,
   input  logic                    i_grant,
   input  logic [N_ENDP-1:0]       i_rdEn,
   input  logic [N_ENDP*IDX_W-1:0] i_rdIdx,
   output logic                    o_rdEn,
   output logic [IDX_W-1:0]        o_rdIdx
);

   // pick the granted endpoint's strobe/index; nothing passes without grant
   always_comb begin
      o_rdEn  = 1'b0;
      o_rdIdx = '0;
      for (int e = 0; e < N_ENDP; e++) begin
         if (i_grant && (i_sel == ENDP_W'(e))) begin
            o_rdEn  = i_rdEn[e];
            o_rdIdx = i_rdIdx[e*IDX_W +: IDX_W];
         end
      end
   end

endmodule

// File: rtl/usbfs_out_sched.sv
// USB FS OUT-packet scheduler: arbitrates the single receive buffer among
// N_ENDP OUT endpoints, returns ACK/NAK/STALL and grants the target endpoint
// exclusive read access until it has drained the packet.
// Optional drain watchdog: define USBFS_OUT_SCHED_TIMEOUT_EN.
module usbfs_out_sched
   import usbfs_pkg::*;
#(
   parameter int N_ENDP  = 4,
   parameter int MAX_PKT = 8,
`ifdef USBFS_OUT_SCHED_TIMEOUT_EN
   parameter int TIMEOUT = 256,
`endif
   localparam int IDX_W    = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1,
   localparam int NBYTES_W = $clog2(MAX_PKT + 1)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_pktValid,
   output logic                    o_pktReady,
   input  logic [ENDP_W-1:0]       i_pktEndp,
   input  logic [NBYTES_W-1:0]     i_pktNBytes,
   output logic                    o_hsAck,
   output logic                    o_hsNak,
   output logic                    o_hsStall,
   output logic                    o_bufRdEn,
   output logic [IDX_W-1:0]        o_bufRdIdx,
   input  logic [7:0]              i_bufRdByte,
   output logic [N_ENDP-1:0]       o_erValid,
   input  logic [N_ENDP-1:0]       i_erReady,
   input  logic [N_ENDP-1:0]       i_erStall,
   input  logic [N_ENDP-1:0]       i_erRdEn,
   input  logic [N_ENDP*IDX_W-1:0] i_erRdIdx,
   output logic [7:0]              o_erRdByte,
   output logic [NBYTES_W-1:0]     o_erRdNBytes
`ifdef USBFS_OUT_SCHED_TIMEOUT_EN
   ,
   output logic                    o_drainErr
`endif
);

   state_e                state_q, state_d;
   logic [ENDP_W-1:0]     endp_q, endp_d;
   logic [NBYTES_W-1:0]   nBytes_q, nBytes_d;
   logic [NBYTES_W-1:0]   cnt_q, cnt_d;

   logic                  grant;
   logic                  hit, selStall, selReady;
   logic [N_ENDP-1:0]     selOneHot;
   hs_e                   dec;

`ifdef USBFS_OUT_SCHED_TIMEOUT_EN
   localparam int WDT_W = $clog2(TIMEOUT + 1);
   logic [WDT_W-1:0]      wdt_q, wdt_d;
`endif

   usbfs_rd_mux #(.N_ENDP(N_ENDP), .IDX_W(IDX_W)) u_rd_mux (
      .i_sel   (endp_q),
      .i_grant (grant),
      .i_rdEn  (i_erRdEn),
      .i_rdIdx (i_erRdIdx),
      .o_rdEn  (o_bufRdEn),
      .o_rdIdx (o_bufRdIdx)
   );

   assign grant        = (state_q == DRAIN);
   assign o_erRdByte   = i_bufRdByte;
   assign o_erRdNBytes = nBytes_q;

   // decode the latched endpoint: out-of-range numbers never match, so they stall
   always_comb begin
      hit       = 1'b0;
      selStall  = 1'b0;
      selReady  = 1'b0;
      selOneHot = '0;
      for (int e = 0; e < N_ENDP; e++) begin
         if (endp_q == ENDP_W'(e)) begin
            hit          = 1'b1;
            selStall     = i_erStall[e];
            selReady     = i_erReady[e];
            selOneHot[e] = 1'b1;
         end
      end
      if (!hit || selStall)  dec = HS_STALL;
      else if (!selReady)    dec = HS_NAK;
      else                   dec = HS_ACK;
   end

   // next-state and output logic
   always_comb begin
      state_d    = state_q;
      endp_d     = endp_q;
      nBytes_d   = nBytes_q;
      cnt_d      = cnt_q;
      o_pktReady = 1'b0;
      o_hsAck    = 1'b0;
      o_hsNak    = 1'b0;
      o_hsStall  = 1'b0;
      o_erValid  = '0;
`ifdef USBFS_OUT_SCHED_TIMEOUT_EN
      wdt_d      = '0;
      o_drainErr = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            o_pktReady = 1'b1;
            if (i_pktValid) begin
               endp_d   = i_pktEndp;
               nBytes_d = i_pktNBytes;
               state_d  = RESP;
            end
         end
         RESP: begin
            unique case (dec)
               HS_STALL: begin
                  o_hsStall = 1'b1;
                  state_d   = IDLE;
               end
               HS_NAK: begin
                  o_hsNak = 1'b1;
                  state_d = IDLE;
               end
               default: begin
                  o_hsAck   = 1'b1;
                  o_erValid = selOneHot;
                  state_d   = (nBytes_q != '0) ? DRAIN : IDLE;
               end
            endcase
         end
         DRAIN: begin
            if (o_bufRdEn) begin
               cnt_d = cnt_q + NBYTES_W'(1);
               if (cnt_q == nBytes_q - NBYTES_W'(1)) begin
                  cnt_d   = '0;
                  state_d = TAIL;
               end
            end
`ifdef USBFS_OUT_SCHED_TIMEOUT_EN
            wdt_d = o_bufRdEn ? '0 : wdt_q + WDT_W'(1);
            // a stuck endpoint releases the buffer so traffic can continue
            if (wdt_q == WDT_W'(TIMEOUT - 1)) begin
               o_drainErr = 1'b1;
               cnt_d      = '0;
               state_d    = IDLE;
            end
`endif
         end
         TAIL: begin
            // buffer still held so the last requested byte comes back intact
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         endp_q   <= '0;
         nBytes_q <= '0;
         cnt_q    <= '0;
`ifdef USBFS_OUT_SCHED_TIMEOUT_EN
         wdt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         endp_q   <= endp_d;
         nBytes_q <= nBytes_d;
         cnt_q    <= cnt_d;
`ifdef USBFS_OUT_SCHED_TIMEOUT_EN
         wdt_q    <= wdt_d;
`endif
      end
   end

   a_erValidOnlyInResp: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (o_erValid != '0) |-> (state_q == RESP));

   a_noReadPastEnd: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(o_bufRdEn && (cnt_q == nBytes_q)));

endmodule

// File: tb/tb_usbfs_out_sched.sv
// Scoreboard bench for usbfs_out_sched: stimulus pushes expected events
// (handshakes, endpoint offers, granted reads, drain errors) with the cycle
// they must appear in; a negedge monitor pops and compares every event the
// DUT presents.
module tb_usbfs_out_sched;

   localparam int N_ENDP   = 4;
   localparam int MAX_PKT  = 8;
   localparam int TIMEOUT  = 16;
   localparam int IDX_W    = $clog2(MAX_PKT);
   localparam int NBYTES_W = $clog2(MAX_PKT + 1);

   typedef struct packed {
      logic [31:0]         cyc;
      logic [2:0]          hs;     // {stall,nak,ack}
      logic [N_ENDP-1:0]   ev;
      logic                rd;
      logic [IDX_W-1:0]    idx;
      logic [NBYTES_W-1:0] nb;
      logic                derr;
   } ev_t;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    i_pktValid = 1'b0;
   logic                    o_pktReady;
   logic [3:0]              i_pktEndp = '0;
   logic [NBYTES_W-1:0]     i_pktNBytes = '0;
   logic                    o_hsAck, o_hsNak, o_hsStall;
   logic                    o_bufRdEn;
   logic [IDX_W-1:0]        o_bufRdIdx;
   logic [7:0]              i_bufRdByte = '0;
   logic [N_ENDP-1:0]       o_erValid;
   logic [N_ENDP-1:0]       i_erReady = '0;
   logic [N_ENDP-1:0]       i_erStall = '0;
   logic [N_ENDP-1:0]       i_erRdEn = '0;
   logic [N_ENDP*IDX_W-1:0] i_erRdIdx = '0;
   logic [7:0]              o_erRdByte;
   logic [NBYTES_W-1:0]     o_erRdNBytes;
   logic                    derr;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   ev_t  sbq[$];
   logic [7:0] mem [MAX_PKT];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // buffer model: data returned one cycle after the read strobe
   always @(posedge clk) if (o_bufRdEn) i_bufRdByte <= mem[o_bufRdIdx];

`ifdef USBFS_OUT_SCHED_TIMEOUT_EN
   logic o_drainErr;
   assign derr = o_drainErr;
   usbfs_out_sched #(.N_ENDP(N_ENDP), .MAX_PKT(MAX_PKT), .TIMEOUT(TIMEOUT)) dut (
`else
   assign derr = 1'b0;
   usbfs_out_sched #(.N_ENDP(N_ENDP), .MAX_PKT(MAX_PKT)) dut (
`endif
      .i_clk(clk), .i_rst_n(rst_n),
      .i_pktValid(i_pktValid), .o_pktReady(o_pktReady),
      .i_pktEndp(i_pktEndp), .i_pktNBytes(i_pktNBytes),
      .o_hsAck(o_hsAck), .o_hsNak(o_hsNak), .o_hsStall(o_hsStall),
      .o_bufRdEn(o_bufRdEn), .o_bufRdIdx(o_bufRdIdx), .i_bufRdByte(i_bufRdByte),
      .o_erValid(o_erValid), .i_erReady(i_erReady), .i_erStall(i_erStall),
      .i_erRdEn(i_erRdEn), .i_erRdIdx(i_erRdIdx),
      .o_erRdByte(o_erRdByte), .o_erRdNBytes(o_erRdNBytes)
`ifdef USBFS_OUT_SCHED_TIMEOUT_EN
      , .o_drainErr(o_drainErr)
`endif
   );

   function automatic ev_t mk(int c, logic [2:0] hs, logic [N_ENDP-1:0] ev, logic rd,
                              int idx, int nb, logic de);
      ev_t r;
      r.cyc = 32'(c); r.hs = hs; r.ev = ev; r.rd = rd;
      r.idx = IDX_W'(idx); r.nb = NBYTES_W'(nb); r.derr = de;
      return r;
   endfunction

   // monitor: every observable event must match the head of the scoreboard
   logic             prevRd = 1'b0;
   logic [IDX_W-1:0] prevIdx = '0;
   always @(negedge clk) begin
      ev_t a, e;
      if (rst_n) begin
         if (prevRd) begin
            checks++;
            if (o_erRdByte !== mem[prevIdx]) begin
               errors++;
               $display("FAIL rdByte: got %0h want %0h", o_erRdByte, mem[prevIdx]);
            end
         end
         a.cyc  = 32'(cyc);
         a.hs   = {o_hsStall, o_hsNak, o_hsAck};
         a.ev   = o_erValid;
         a.rd   = o_bufRdEn;
         a.idx  = o_bufRdEn ? o_bufRdIdx : '0;
         a.nb   = o_bufRdEn ? o_erRdNBytes : '0;
         a.derr = derr;
         if (a.hs != 3'b000 || a.ev != '0 || a.rd || a.derr) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL unexpected event: got %h want none", a);
            end else begin
               e = sbq.pop_front();
               if (a !== e) begin
                  errors++;
                  $display("FAIL scoreboard: got cyc=%0d hs=%b ev=%b rd=%b idx=%0d nb=%0d derr=%b want cyc=%0d hs=%b ev=%b rd=%b idx=%0d nb=%0d derr=%b",
                           a.cyc, a.hs, a.ev, a.rd, a.idx, a.nb, a.derr,
                           e.cyc, e.hs, e.ev, e.rd, e.idx, e.nb, e.derr);
               end
            end
         end
      end
      prevRd  <= rst_n && o_bufRdEn;
      prevIdx <= o_bufRdIdx;
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // offer one packet; returns acceptance cycle and whether a drain follows
   task automatic send(int endp, int n, logic rdy, logic stl, output int acc, output bit drains);
      int k;
      logic [2:0] hs;
      k = 0;
      while (!o_pktReady && k < 50) begin step(); k++; end
      chk("pktReady_wait", 32'(o_pktReady), 32'd1);
      i_erReady = N_ENDP'($urandom);
      i_erStall = N_ENDP'($urandom);
      if (endp < N_ENDP) begin
         i_erReady[endp] = rdy;
         i_erStall[endp] = stl;
      end
      i_pktValid  = 1'b1;
      i_pktEndp   = 4'(endp);
      i_pktNBytes = NBYTES_W'(n);
      acc = cyc;
      // reference decision
      if (endp >= N_ENDP || stl)  hs = 3'b100;
      else if (!rdy)              hs = 3'b010;
      else                        hs = 3'b001;
      drains = (hs == 3'b001) && (n != 0);
      sbq.push_back(mk(acc + 1, hs, (hs == 3'b001) ? N_ENDP'(1 << endp) : '0, 1'b0, 0, 0, 1'b0));
      step();
      i_pktValid = 1'b0;
      step();
      if (!drains) chk("idle_after_resp", 32'(o_pktReady), 32'd1);
      else         chk("busy_in_drain", 32'(o_pktReady), 32'd0);
   endtask

   // target endpoint reads n bytes at random pace; others strobe as noise
   task automatic drain(int endp, int n);
      int got, idle, budget;
      logic s;
      got = 0; idle = 0; budget = 0;
      while (got < n && budget < 200) begin
         s = ($urandom_range(0, 2) != 0) || (idle >= 4);
         i_erRdEn  = N_ENDP'($urandom);
         i_erRdIdx = (N_ENDP*IDX_W)'($urandom);
         i_erRdEn[endp] = s;
         if (s) begin
            i_erRdIdx[endp*IDX_W +: IDX_W] = IDX_W'(got);
            sbq.push_back(mk(cyc, 3'b000, '0, 1'b1, got, n, 1'b0));
            got++; idle = 0;
         end else idle++;
         step(); budget++;
      end
      i_erRdEn = '0;
      chk("tail_busy", 32'(o_pktReady), 32'd0);
      step();
      chk("drain_done", 32'(o_pktReady), 32'd1);
   endtask

   initial begin
      int  acc;
      bit  dr;
      int  e, n;
      foreach (mem[i]) mem[i] = 8'($urandom);

      // reset state
      step(); step();
      chk("rst_pktReady", 32'(o_pktReady), 32'd1);
      chk("rst_hs", 32'({o_hsAck, o_hsNak, o_hsStall}), 32'd0);
      chk("rst_erValid", 32'(o_erValid), 32'd0);
      chk("rst_bufRdEn", 32'(o_bufRdEn), 32'd0);
      chk("rst_nBytes", 32'(o_erRdNBytes), 32'd0);
      rst_n = 1'b1;
      step();

      // directed cases
      send(2, 3, 1'b1, 1'b0, acc, dr); if (dr) drain(2, 3);
      send(1, 4, 1'b0, 1'b0, acc, dr);
      send(7, 2, 1'b1, 1'b0, acc, dr);
      send(0, 2, 1'b1, 1'b1, acc, dr);
      send(3, 0, 1'b1, 1'b0, acc, dr);
      send(1, MAX_PKT, 1'b1, 1'b0, acc, dr); if (dr) drain(1, MAX_PKT);
      send(15, 1, 1'b1, 1'b0, acc, dr);

      // randomized traffic
      for (int p = 0; p < 30; p++) begin
         e = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, N_ENDP-1));
         n = $urandom_range(0, MAX_PKT);
         send(e, n, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), acc, dr);
         if (dr) drain(e, n);
         repeat ($urandom_range(0, 2)) step();
      end

      // reset mid-drain, with endpoint 1 strobing throughout
      send(0, 5, 1'b1, 1'b0, acc, dr);
      for (int c = 0; c < 4; c++) begin
         i_erRdEn = '0;
         i_erRdEn[1] = 1'b1;
         i_erRdIdx = (N_ENDP*IDX_W)'($urandom);
         if (c == 1 || c == 3) begin
            i_erRdEn[0] = 1'b1;
            i_erRdIdx[0 +: IDX_W] = IDX_W'(c / 2);
            sbq.push_back(mk(cyc, 3'b000, '0, 1'b1, c / 2, 5, 1'b0));
         end
         step();
      end
      i_erRdEn[0] = 1'b1;
      rst_n = 1'b0;
      #2;
      chk("midrst_pktReady", 32'(o_pktReady), 32'd1);
      chk("midrst_bufRdEn", 32'(o_bufRdEn), 32'd0);
      chk("midrst_hs", 32'({o_hsAck, o_hsNak, o_hsStall, o_erValid}), 32'd0);
      step(); step();
      rst_n = 1'b1;
      step();
      chk("postrst_pktReady", 32'(o_pktReady), 32'd1);
      chk("postrst_bufRdEn", 32'(o_bufRdEn), 32'd0);
      chk("postrst_nBytes", 32'(o_erRdNBytes), 32'd0);
      i_erRdEn = '0;

`ifdef USBFS_OUT_SCHED_TIMEOUT_EN
      // stuck endpoint: watchdog fires on DRAIN cycle TIMEOUT
      send(2, 4, 1'b1, 1'b0, acc, dr);
      sbq.push_back(mk(acc + 1 + TIMEOUT, 3'b000, '0, 1'b0, 0, 0, 1'b1));
      while (cyc < acc + 1 + TIMEOUT) begin
         i_erRdEn = N_ENDP'($urandom);
         i_erRdEn[2] = 1'b0;
         step();
      end
      i_erRdEn = '0;
      chk("wdt_busy", 32'(o_pktReady), 32'd0);
      step();
      chk("wdt_idle", 32'(o_pktReady), 32'd1);
      send(2, 2, 1'b1, 1'b0, acc, dr); if (dr) drain(2, 2);
`else
      // without the watchdog a silent endpoint holds the buffer
      send(2, 3, 1'b1, 1'b0, acc, dr);
      repeat (40) begin
         i_erRdEn = N_ENDP'($urandom);
         i_erRdEn[2] = 1'b0;
         step();
      end
      chk("hold_busy", 32'(o_pktReady), 32'd0);
      drain(2, 3);
`endif

      repeat (3) step();
      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end

endmodule
